branch_pred_resolve: RTL and testbench

- Parametrised successor to the execute-stage branch comparator.
- Resolves RV32I conditional branches and JAL/JALR in EX for any XLEN.
- Owns a direct-mapped branch history table (BHT) of 2-bit saturating counters, read at fetch and trained at EX.
- Flags mispredictions for the flush/redirect logic and keeps saturating performance counters.

---
 rtl/branch_pred_resolve_if.sv | 33 +++
 rtl/branch_pred_resolve.sv | 121 ++++++++++++
 tb/tb_branch_pred_resolve.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_pred_resolve_if.sv
// rtl/branch_pred_resolve_if.sv - fetch/EX/stats signal bundle for the branch resolver
interface branch_pred_resolve_if #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic [PC_W-1:0]  fetch_pc;
    logic             pred_taken;
    logic             ex_valid;
    logic [PC_W-1:0]  ex_pc;
    logic [6:0]       ex_opcode;
    logic [2:0]       ex_br_type;
    logic             ex_pred_taken;
    logic [XLEN-1:0]  rdata1;
    logic [XLEN-1:0]  rdata2;
    logic             br_taken;
    logic             mispredict;
    logic             clear_stats;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output fetch_pc, ex_valid, ex_pc, ex_opcode, ex_br_type, ex_pred_taken,
               rdata1, rdata2, clear_stats,
        input  pred_taken, br_taken, mispredict, branch_count, mispredict_count
    );

    modport slave (
        input  fetch_pc, ex_valid, ex_pc, ex_opcode, ex_br_type, ex_pred_taken,
               rdata1, rdata2, clear_stats,
        output pred_taken, br_taken, mispredict, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_pred_resolve.sv
// rtl/branch_pred_resolve.sv - EX-stage branch resolution with 2-bit BHT and perf counters
module branch_pred_resolve #(
    parameter int XLEN        = 32,
    parameter int PC_W        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    branch_pred_resolve_if.slave   bus
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [1:0]       bht_cur;
    logic [1:0]       bht_d;
    logic             bht_we;
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] misp_cnt_q, misp_cnt_d;
    logic [XLEN:0]    diff;
    logic             eq, ult, slt, ovf;
    logic             br_taken;
    logic             mispredict;
    logic             unused_pc_bits;

    assign fetch_idx = bus.fetch_pc[IDX_W+1:2];
    assign ex_idx    = bus.ex_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{bus.fetch_pc[1:0], bus.fetch_pc[PC_W-1:IDX_W+2],
                              bus.ex_pc[1:0], bus.ex_pc[PC_W-1:IDX_W+2]};

    // One widened subtraction yields all three relations: borrow gives unsigned,
    // sign xor overflow gives signed.
    always_comb begin
        diff = {1'b0, bus.rdata1} - {1'b0, bus.rdata2};
        eq   = (bus.rdata1 == bus.rdata2);
        ult  = diff[XLEN];
        ovf  = (bus.rdata1[XLEN-1] ^ bus.rdata2[XLEN-1]) &
               (bus.rdata1[XLEN-1] ^ diff[XLEN-1]);
        slt  = diff[XLEN-1] ^ ovf;
    end

    always_comb begin
        br_taken = 1'b0;
        if (bus.ex_valid) begin
            case (bus.ex_opcode)
                OP_BRANCH: begin
                    case (bus.ex_br_type)
                        3'b000:  br_taken = eq;
                        3'b001:  br_taken = ~eq;
                        3'b100:  br_taken = slt;
                        3'b101:  br_taken = ~slt;
                        3'b110:  br_taken = ult;
                        3'b111:  br_taken = ~ult;
                        default: br_taken = 1'b0;
                    endcase
                end
                OP_JAL, OP_JALR: br_taken = 1'b1;
                default:         br_taken = 1'b0;
            endcase
        end
    end

    assign mispredict = bus.ex_valid & (br_taken != bus.ex_pred_taken);

    // Only legal conditional branches train; jumps would pollute the counters.
    always_comb begin
        bht_we  = bus.ex_valid && (bus.ex_opcode == OP_BRANCH) &&
                  (bus.ex_br_type[2:1] != 2'b01);
        bht_cur = bht_q[ex_idx];
        bht_d   = bht_cur;
        if (br_taken) begin
            if (bht_cur != 2'b11) bht_d = bht_cur + 2'd1;
        end else begin
            if (bht_cur != 2'b00) bht_d = bht_cur - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
        end else if (bht_we) begin
            bht_q[ex_idx] <= bht_d;
        end
    end

    always_comb begin
        branch_cnt_d = branch_cnt_q;
        misp_cnt_d   = misp_cnt_q;
        if (bus.clear_stats) begin
            branch_cnt_d = '0;
            misp_cnt_d   = '0;
        end else begin
            if (bht_we && branch_cnt_q != CNT_MAX) branch_cnt_d = branch_cnt_q + CNT_ONE;
            if (mispredict && misp_cnt_q != CNT_MAX) misp_cnt_d = misp_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q <= '0;
            misp_cnt_q   <= '0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            misp_cnt_q   <= misp_cnt_d;
        end
    end

    // Fetch reads the registered table directly, so a same-cycle train is seen next cycle.
    assign bus.pred_taken       = bht_q[fetch_idx][1];
    assign bus.br_taken         = br_taken;
    assign bus.mispredict       = mispredict;
    assign bus.branch_count     = branch_cnt_q;
    assign bus.mispredict_count = misp_cnt_q;
endmodule

// File: tb/tb_branch_pred_resolve.sv
// tb/tb_branch_pred_resolve.sv - self-checking bench for branch_pred_resolve
module tb_branch_pred_resolve;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;

    logic        clk;
    logic        rst_n;
    logic [31:0] fetch_pc, ex_pc, rdata1, rdata2;
    logic        ex_valid, ex_pred_taken, clear_stats;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_br_type;

    int total = 0;
    int bad   = 0;

    int m_bht [16];
    int m_bc, m_mc;

    branch_pred_resolve_if #(.XLEN(32), .PC_W(32), .CNT_W(16)) bus_a ();
    branch_pred_resolve_if #(.XLEN(32), .PC_W(32), .CNT_W(2))  bus_b ();

    assign bus_a.fetch_pc = fetch_pc;       assign bus_b.fetch_pc = fetch_pc;
    assign bus_a.ex_valid = ex_valid;       assign bus_b.ex_valid = ex_valid;
    assign bus_a.ex_pc = ex_pc;             assign bus_b.ex_pc = ex_pc;
    assign bus_a.ex_opcode = ex_opcode;     assign bus_b.ex_opcode = ex_opcode;
    assign bus_a.ex_br_type = ex_br_type;   assign bus_b.ex_br_type = ex_br_type;
    assign bus_a.ex_pred_taken = ex_pred_taken; assign bus_b.ex_pred_taken = ex_pred_taken;
    assign bus_a.rdata1 = rdata1;           assign bus_b.rdata1 = rdata1;
    assign bus_a.rdata2 = rdata2;           assign bus_b.rdata2 = rdata2;
    assign bus_a.clear_stats = clear_stats; assign bus_b.clear_stats = clear_stats;

    branch_pred_resolve #(.XLEN(32), .PC_W(32), .BHT_ENTRIES(16), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    branch_pred_resolve #(.XLEN(32), .PC_W(32), .BHT_ENTRIES(16), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int midx(input logic [31:0] pc);
        return int'((pc >> 2) & 32'hF);
    endfunction

    function automatic bit ref_taken(input bit v, input logic [6:0] op, input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] b);
        if (!v) return 1'b0;
        if (op == JAL || op == JALR) return 1'b1;
        if (op != BR) return 1'b0;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) <  $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a <  b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
        m_bc = 0;
        m_mc = 0;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, ".bc_a"}, 32'(bus_a.branch_count),     32'(sat(m_bc, 65535)));
        chk({tag, ".mc_a"}, 32'(bus_a.mispredict_count), 32'(sat(m_mc, 65535)));
        chk({tag, ".bc_b"}, 32'(bus_b.branch_count),     32'(sat(m_bc, 3)));
        chk({tag, ".mc_b"}, 32'(bus_b.mispredict_count), 32'(sat(m_mc, 3)));
    endtask

    // One EX cycle: drive after the edge, check combinational results mid-cycle,
    // advance the model at the edge, then check the counters.
    task automatic cyc(input string tag, input bit v, input logic [6:0] op, input logic [2:0] f3,
                       input bit pt, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] fpc, input bit clr);
        bit t, legal;
        ex_valid = v; ex_opcode = op; ex_br_type = f3; ex_pred_taken = pt;
        rdata1 = a; rdata2 = b; ex_pc = pc; fetch_pc = fpc; clear_stats = clr;
        @(negedge clk);
        t = ref_taken(v, op, f3, a, b);
        chk({tag, ".br"},   32'(bus_a.br_taken),   32'(t));
        chk({tag, ".misp"}, 32'(bus_a.mispredict), 32'(v && (t != pt)));
        chk({tag, ".pred"}, 32'(bus_a.pred_taken), 32'(m_bht[midx(fpc)] >= 2));
        chk({tag, ".br_b"}, 32'(bus_b.br_taken),   32'(t));
        @(posedge clk);
        legal = v && op == BR && f3 != 3'd2 && f3 != 3'd3;
        if (legal) begin
            m_bht[midx(pc)] = t ? sat(m_bht[midx(pc)] + 1, 3)
                                : ((m_bht[midx(pc)] > 0) ? m_bht[midx(pc)] - 1 : 0);
        end
        if (clr) begin
            m_bc = 0;
            m_mc = 0;
        end else begin
            if (legal) m_bc++;
            if (v && (t != pt)) m_mc++;
        end
        #1;
        chk_counts(tag);
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_opcode = 7'd0; ex_br_type = 3'd0; ex_pred_taken = 1'b0;
        rdata1 = 32'd0; rdata2 = 32'd0; ex_pc = 32'd0; clear_stats = 1'b0;
    endtask

    initial begin
        logic [31:0] a, b, pc, fpc;
        logic [6:0]  op;
        logic [2:0]  f3;
        bit          v, pt, clr;
        int          r;

        idle();
        fetch_pc = 32'h40;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        #2;
        chk("reset.pred", 32'(bus_a.pred_taken), 32'd0);
        chk_counts("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset.pred_after", 32'(bus_a.pred_taken), 32'd0);
        chk_counts("reset_after");

        cyc("blt",  1, BR, 3'd4, 0, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 0);
        cyc("bltu", 1, BR, 3'd6, 0, 32'hFFFFFFFF, 32'd1, 32'h204, 32'h40, 0);
        cyc("bge",  1, BR, 3'd5, 0, 32'h80000000, 32'h7FFFFFFF, 32'h208, 32'h40, 0);
        cyc("beq",  1, BR, 3'd0, 1, 32'h1234, 32'h1234, 32'h20C, 32'h40, 0);
        cyc("clr0", 0, 7'd0, 3'd0, 0, 32'd0, 32'd0, 32'd0, 32'h40, 1);

        cyc("train1", 1, BR, 3'd0, 0, 32'h5, 32'h5, 32'h100, 32'h40, 0);
        cyc("train2", 1, BR, 3'd0, 1, 32'h5, 32'h5, 32'h100, 32'h100, 0);
        chk("train.bc", 32'(bus_a.branch_count), 32'd2);
        chk("train.mc", 32'(bus_a.mispredict_count), 32'd1);

        cyc("nt1", 1, BR, 3'd1, 1, 32'h9, 32'h9, 32'h100, 32'h100, 0);
        cyc("nt2", 1, BR, 3'd1, 1, 32'h9, 32'h9, 32'h100, 32'h100, 0);
        cyc("nt3", 1, BR, 3'd1, 0, 32'h9, 32'h9, 32'h100, 32'h100, 0);
        cyc("nt4", 1, BR, 3'd1, 0, 32'h9, 32'h9, 32'h100, 32'h100, 0);
        chk("sat.model00", 32'(m_bht[0]), 32'd0);

        cyc("jalr",  1, JALR, 3'd0, 0, 32'd0, 32'd0, 32'h100, 32'h100, 0);
        cyc("f3_010", 1, BR, 3'd2, 0, 32'd3, 32'd3, 32'h100, 32'h100, 0);
        cyc("f3_chk", 0, 7'd0, 3'd0, 0, 32'd0, 32'd0, 32'd0, 32'h100, 0);

        cyc("clr_misp", 1, JAL, 3'd0, 0, 32'd0, 32'd0, 32'h300, 32'h40, 1);
        chk("clr.bc", 32'(bus_a.branch_count), 32'd0);
        chk("clr.mc", 32'(bus_a.mispredict_count), 32'd0);
        for (int i = 0; i < 5; i++)
            cyc("misp5", 1, JAL, 3'd0, 0, 32'd0, 32'd0, 32'h300, 32'h40, 0);
        chk("sat.mc_b", 32'(bus_b.mispredict_count), 32'd3);
        chk("sat.mc_a", 32'(bus_a.mispredict_count), 32'd5);

        cyc("pre_rst", 1, BR, 3'd0, 0, 32'd1, 32'd1, 32'h104, 32'h104, 0);
        cyc("pre_rst2", 1, BR, 3'd0, 1, 32'd1, 32'd1, 32'h104, 32'h104, 0);
        idle();
        fetch_pc = 32'h104;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst.pred", 32'(bus_a.pred_taken), 32'd0);
        chk_counts("midrst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        cyc("post_rst", 0, 7'd0, 3'd0, 0, 32'd0, 32'd0, 32'd0, 32'h104, 0);

        for (int n = 0; n < 400; n++) begin
            r  = int'($urandom_range(0, 9));
            v  = (r != 9);
            op = (r <= 5 || r == 9) ? BR : (r == 6) ? JAL : (r == 7) ? JALR : 7'($urandom);
            f3 = 3'($urandom);
            a  = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = $urandom;
                2: begin a = 32'h80000000; b = 32'h7FFFFFFF; end
                default: begin a = 32'hFFFFFFFF; b = $urandom_range(0, 3); end
            endcase
            if ($urandom_range(0, 1) == 0) begin
                logic [31:0] tmp;
                tmp = a; a = b; b = tmp;
            end
            pc  = {22'($urandom), 8'($urandom_range(0, 255)) & 8'hFC, 2'b00};
            fpc = ($urandom_range(0, 2) == 0) ? pc : {$urandom_range(0, 1023), 2'b00};
            pt  = (op == BR) ? ((m_bht[midx(pc)] >= 2) ^ ($urandom_range(0, 4) == 0)) : 1'($urandom);
            clr = ($urandom_range(0, 24) == 0);
            cyc("rand", v, op, f3, pt, a, b, pc, fpc, clr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
